// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run/step/halt sequencer: host commands,
// sequencer states and stop causes. The bench imports these too.
package cpu_run_ctrl_pkg;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  localparam logic [1:0] S_RESET  = 2'b00;
  localparam logic [1:0] S_IDLE   = 2'b01;
  localparam logic [1:0] S_RUN    = 2'b10;
  localparam logic [1:0] S_STEP   = 2'b11;

  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_HOST     = 3'd1;
  localparam logic [2:0] CAUSE_BUDGET   = 3'd2;
  localparam logic [2:0] CAUSE_BREAK    = 3'd3;
  localparam logic [2:0] CAUSE_CPU_HALT = 3'd4;
  localparam logic [2:0] CAUSE_STEP     = 3'd5;

endpackage

// File: rtl/cpu_ctrl_dcnt.sv
// Loadable down-counter for the RUN instruction budget. Holds at zero, so a
// zero load (unlimited budget) never moves and never reports expiry.
module cpu_ctrl_dcnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer: gates the core clock enable and holds the core in
// reset, stopping on budget expiry, PC breakpoint, core halt or host HALT.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int PC_W       = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic             inclk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_pc,
  input  logic [PC_W-1:0]  cpu_pc,
  input  logic             cpu_halt_req,
  output logic             cpu_en,
  output logic             cpu_rstn_o,
  output logic [1:0]       state,
  output logic [2:0]       stop_cause,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [RC_W-1:0]  rst_cnt;
  logic             first;
  logic             in_run;
  logic             in_step;
  logic             halt_acc;
  logic             bp_hit;
  logic             run_load;
  logic             run_stop;
  logic [2:0]       run_cause;
  logic [CNT_W-1:0] budget;
  logic             budget_zero;

  assign in_run   = (state == S_RUN);
  assign in_step  = (state == S_STEP);
  assign halt_acc = in_run && cmd_valid && (cmd_op == OP_HALT);
  assign bp_hit   = in_run && bp_en && (cpu_pc == bp_pc) && !first;
  assign cpu_en   = in_step || (in_run && !bp_hit && !halt_acc);
  assign run_load = (state == S_IDLE) && cmd_valid && (cmd_op == OP_RUN);

  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      S_IDLE:  cmd_ready = 1'b1;
      S_RUN:   cmd_ready = cmd_valid && (cmd_op == OP_HALT);
      default: cmd_ready = 1'b0;
    endcase
  end

  // Stop priority in RUN: core halt, then budget, then breakpoint, then host.
  // A budget of zero leaves the counter parked at zero, so it never reads 1.
  always_comb begin
    run_stop  = 1'b1;
    run_cause = CAUSE_NONE;
    if (cpu_halt_req && cpu_en) begin
      run_cause = CAUSE_CPU_HALT;
    end else if (cpu_en && (budget == CNT_W'(1))) begin
      run_cause = CAUSE_BUDGET;
    end else if (bp_hit) begin
      run_cause = CAUSE_BREAK;
    end else if (halt_acc) begin
      run_cause = CAUSE_HOST;
    end else begin
      run_stop = 1'b0;
    end
  end

  cpu_ctrl_dcnt #(.W(CNT_W)) u_budget (
    .clk      (inclk),
    .rst_n    (rstn),
    .load     (run_load),
    .load_val (cmd_arg),
    .dec      (in_run && cpu_en),
    .count    (budget),
    .zero     (budget_zero)
  );

  always_ff @(posedge inclk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_RESET;
      cpu_rstn_o <= 1'b0;
      stop_cause <= CAUSE_NONE;
      done       <= 1'b0;
      retired    <= '0;
      rst_cnt    <= '0;
      first      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cpu_en && (retired != '1)) begin
        retired <= retired + CNT_W'(1);
      end
      case (state)
        S_RESET: begin
          if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            state      <= S_IDLE;
            cpu_rstn_o <= 1'b1;
            rst_cnt    <= '0;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_RESET: begin
                state      <= S_RESET;
                cpu_rstn_o <= 1'b0;
                rst_cnt    <= '0;
                retired    <= '0;
                stop_cause <= CAUSE_NONE;
              end
              OP_RUN: begin
                state <= S_RUN;
                first <= 1'b1;
              end
              OP_STEP: state <= S_STEP;
              default: stop_cause <= CAUSE_HOST;
            endcase
          end
        end
        S_RUN: begin
          first <= 1'b0;
          if (run_stop) begin
            state      <= S_IDLE;
            stop_cause <= run_cause;
            done       <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          done       <= 1'b1;
          stop_cause <= cpu_halt_req ? CAUSE_CPU_HALT : CAUSE_STEP;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = budget_zero;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset, budgeted RUN, breakpoints, core
// halt, single-stepping, command stalls and resets mid-run.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  logic        inclk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        bp_en;
  logic [31:0] bp_pc;
  logic [31:0] cpu_pc;
  logic        cpu_halt_req;
  logic        cpu_en;
  logic        cpu_rstn_o;
  logic [1:0]  state;
  logic [2:0]  stop_cause;
  logic        done;
  logic [31:0] retired;

  int tests;
  int failed;
  int n;
  int en_cnt;
  int low_cnt;
  logic en_seen;
  logic done_seen;
  logic last_en;
  logic was_en;

  cpu_run_ctrl dut (
    .inclk        (inclk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .bp_en        (bp_en),
    .bp_pc        (bp_pc),
    .cpu_pc       (cpu_pc),
    .cpu_halt_req (cpu_halt_req),
    .cpu_en       (cpu_en),
    .cpu_rstn_o   (cpu_rstn_o),
    .state        (state),
    .stop_cause   (stop_cause),
    .done         (done),
    .retired      (retired)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
    #1;
  endtask

  // Counts the cycles the core is held in reset; cpu_en and done must stay low.
  task automatic waitReset(input string tag);
    low_cnt   = 0;
    n         = 0;
    en_seen   = 1'b0;
    done_seen = 1'b0;
    while (state == S_RESET && n < 20) begin
      if (!cpu_rstn_o) low_cnt++;
      if (cpu_en) en_seen = 1'b1;
      if (done) done_seen = 1'b1;
      tick();
      n++;
    end
    checkOutput({tag, "_low_cycles"}, 64'(low_cnt), 64'd4);
    checkOutput({tag, "_idle"}, 64'(state), 64'(S_IDLE));
    checkOutput({tag, "_rstn_hi"}, 64'(cpu_rstn_o), 64'd1);
    checkOutput({tag, "_en_never"}, 64'(en_seen), 64'd0);
    checkOutput({tag, "_no_done"}, 64'(done_seen), 64'd0);
  endtask

  // Simple core model: PC advances by 4 on every enabled cycle.
  task automatic runUntilIdle();
    n       = 0;
    en_cnt  = 0;
    last_en = 1'b1;
    while (state != S_IDLE && n < 200) begin
      was_en  = cpu_en;
      last_en = cpu_en;
      if (was_en) en_cnt++;
      tick();
      if (was_en) cpu_pc = cpu_pc + 32'd4;
      #1;
      n++;
    end
    checkOutput("run_reaches_idle", 64'(state), 64'(S_IDLE));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests        = 0;
    failed       = 0;
    rstn         = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = OP_RESET;
    cmd_arg      = '0;
    bp_en        = 1'b0;
    bp_pc        = '0;
    cpu_pc       = '0;
    cpu_halt_req = 1'b0;

    #1;
    checkOutput("reset_state", 64'(state), 64'(S_RESET));
    checkOutput("reset_cpu_rstn", 64'(cpu_rstn_o), 64'd0);
    checkOutput("reset_cpu_en", 64'(cpu_en), 64'd0);
    checkOutput("reset_cause", 64'(stop_cause), 64'(CAUSE_NONE));
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_retired", 64'(retired), 64'd0);
    checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    #9;
    rstn = 1'b1;
    #1;
    waitReset("por");
    checkOutput("por_retired", 64'(retired), 64'd0);

    applyStimulus(1'b1, OP_RUN, 32'd5);
    checkOutput("run5_ready", 64'(cmd_ready), 64'd1);
    tick();
    applyStimulus(1'b0, OP_RESET, 32'd0);
    runUntilIdle();
    checkOutput("run5_en_cycles", 64'(en_cnt), 64'd5);
    checkOutput("run5_cause", 64'(stop_cause), 64'(CAUSE_BUDGET));
    checkOutput("run5_done", 64'(done), 64'd1);
    checkOutput("run5_retired", 64'(retired), 64'd5);
    tick();
    checkOutput("run5_done_pulse", 64'(done), 64'd0);

    applyStimulus(1'b1, OP_HALT, 32'd0);
    tick();
    applyStimulus(1'b0, OP_RESET, 32'd0);
    checkOutput("idle_halt_cause", 64'(stop_cause), 64'(CAUSE_HOST));
    checkOutput("idle_halt_done", 64'(done), 64'd0);
    checkOutput("idle_halt_state", 64'(state), 64'(S_IDLE));

    bp_en  = 1'b1;
    bp_pc  = 32'h10;
    cpu_pc = 32'h0;
    applyStimulus(1'b1, OP_RUN, 32'd0);
    tick();
    applyStimulus(1'b0, OP_RESET, 32'd0);
    runUntilIdle();
    checkOutput("bp_en_cycles", 64'(en_cnt), 64'd4);
    checkOutput("bp_last_en", 64'(last_en), 64'd0);
    checkOutput("bp_pc", 64'(cpu_pc), 64'h10);
    checkOutput("bp_cause", 64'(stop_cause), 64'(CAUSE_BREAK));
    checkOutput("bp_retired", 64'(retired), 64'd9);

    applyStimulus(1'b1, OP_RUN, 32'd0);
    tick();
    applyStimulus(1'b0, OP_RESET, 32'd0);
    checkOutput("bp_resume_en", 64'(cpu_en), 64'd1);
    tick();
    cpu_pc = 32'h14;
    applyStimulus(1'b1, OP_HALT, 32'd0);
    checkOutput("host_halt_ready", 64'(cmd_ready), 64'd1);
    checkOutput("host_halt_en", 64'(cpu_en), 64'd0);
    tick();
    applyStimulus(1'b0, OP_RESET, 32'd0);
    checkOutput("host_halt_state", 64'(state), 64'(S_IDLE));
    checkOutput("host_halt_cause", 64'(stop_cause), 64'(CAUSE_HOST));
    checkOutput("host_halt_done", 64'(done), 64'd1);
    checkOutput("host_halt_retired", 64'(retired), 64'd10);
    bp_en  = 1'b0;
    cpu_pc = 32'h0;

    applyStimulus(1'b1, OP_RUN, 32'd0);
    tick();
    applyStimulus(1'b0, OP_RESET, 32'd0);
    en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) cpu_halt_req = 1'b1;
      #1;
      if (cpu_en) en_cnt++;
      tick();
    end
    cpu_halt_req = 1'b0;
    #1;
    checkOutput("cpuhalt_state", 64'(state), 64'(S_IDLE));
    checkOutput("cpuhalt_en_cycles", 64'(en_cnt), 64'd3);
    checkOutput("cpuhalt_cause", 64'(stop_cause), 64'(CAUSE_CPU_HALT));
    checkOutput("cpuhalt_retired", 64'(retired), 64'd13);

    applyStimulus(1'b1, OP_RUN, 32'd2);
    tick();
    applyStimulus(1'b0, OP_RESET, 32'd0);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) cpu_halt_req = 1'b1;
      #1;
      tick();
    end
    cpu_halt_req = 1'b0;
    #1;
    checkOutput("halt_vs_budget_state", 64'(state), 64'(S_IDLE));
    checkOutput("halt_vs_budget_cause", 64'(stop_cause), 64'(CAUSE_CPU_HALT));
    checkOutput("halt_vs_budget_retired", 64'(retired), 64'd15);

    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, OP_STEP, 32'd0);
      checkOutput("step_ready", 64'(cmd_ready), 64'd1);
      tick();
      applyStimulus(1'b0, OP_RESET, 32'd0);
      checkOutput("step_state", 64'(state), 64'(S_STEP));
      checkOutput("step_en", 64'(cpu_en), 64'd1);
      tick();
      checkOutput("step_idle", 64'(state), 64'(S_IDLE));
      checkOutput("step_cause", 64'(stop_cause), 64'(CAUSE_STEP));
      checkOutput("step_done", 64'(done), 64'd1);
      checkOutput("step_retired", 64'(retired), 64'(16 + s));
    end

    applyStimulus(1'b1, OP_RUN, 32'd0);
    tick();
    applyStimulus(1'b1, OP_STEP, 32'd0);
    checkOutput("stall_step_ready", 64'(cmd_ready), 64'd0);
    checkOutput("stall_step_en", 64'(cpu_en), 64'd1);
    checkOutput("stall_cause_hold", 64'(stop_cause), 64'(CAUSE_STEP));
    tick();
    checkOutput("stall_step_state", 64'(state), 64'(S_RUN));
    applyStimulus(1'b1, OP_RUN, 32'd7);
    checkOutput("stall_run_ready", 64'(cmd_ready), 64'd0);
    tick();
    checkOutput("stall_run_state", 64'(state), 64'(S_RUN));
    applyStimulus(1'b1, OP_HALT, 32'd0);
    checkOutput("stall_halt_ready", 64'(cmd_ready), 64'd1);
    tick();
    applyStimulus(1'b0, OP_RESET, 32'd0);
    checkOutput("stall_halt_state", 64'(state), 64'(S_IDLE));
    checkOutput("stall_halt_cause", 64'(stop_cause), 64'(CAUSE_HOST));
    checkOutput("stall_halt_retired", 64'(retired), 64'd20);

    applyStimulus(1'b1, OP_RUN, 32'd0);
    tick();
    applyStimulus(1'b0, OP_RESET, 32'd0);
    checkOutput("abort_pre_en", 64'(cpu_en), 64'd1);
    tick();
    rstn = 1'b0;
    #1;
    checkOutput("abort_en", 64'(cpu_en), 64'd0);
    checkOutput("abort_state", 64'(state), 64'(S_RESET));
    checkOutput("abort_retired", 64'(retired), 64'd0);
    checkOutput("abort_cpu_rstn", 64'(cpu_rstn_o), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    #1;
    rstn = 1'b1;
    waitReset("abort");

    applyStimulus(1'b1, OP_STEP, 32'd0);
    tick();
    applyStimulus(1'b0, OP_RESET, 32'd0);
    tick();
    checkOutput("prereset_retired", 64'(retired), 64'd1);
    applyStimulus(1'b1, OP_RESET, 32'd0);
    tick();
    applyStimulus(1'b0, OP_RESET, 32'd0);
    checkOutput("cmdreset_state", 64'(state), 64'(S_RESET));
    checkOutput("cmdreset_retired", 64'(retired), 64'd0);
    checkOutput("cmdreset_cause", 64'(stop_cause), 64'(CAUSE_NONE));
    checkOutput("cmdreset_cpu_rstn", 64'(cpu_rstn_o), 64'd0);
    waitReset("cmdreset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
